// File: rtl/dma_priority_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : dma_priority_arbiter_if
// Brief   : Request/acknowledge bundle between the DMA register file, the CPU
//           hold handshake and the channel arbiter.
// Rev     : 1.0  initial release
// ============================================================================
interface dma_priority_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int CHW    = $clog2(NUM_CH)
) ();
    logic [NUM_CH-1:0] dreq;
    logic              dreq_active_low;
    logic              dack_active_high;
    logic              rotating_en;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] sw_req;
    logic              hlda;
    logic              xfer_done;
    logic              hrq;
    logic [NUM_CH-1:0] dack;
    logic              grant_valid;
    logic [CHW-1:0]    grant_ch;
    logic              timeout_err;

    modport master (
        output dreq, dreq_active_low, dack_active_high, rotating_en,
        output mask, sw_req, hlda, xfer_done,
        input  hrq, dack, grant_valid, grant_ch, timeout_err
    );

    modport slave (
        input  dreq, dreq_active_low, dack_active_high, rotating_en,
        input  mask, sw_req, hlda, xfer_done,
        output hrq, dack, grant_valid, grant_ch, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/dma_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dma_priority_arbiter
// Brief   : N-channel DREQ arbiter with HRQ/HLDA/DACK sequencing. Optional
//           HLDA timeout is enabled by defining DMA_ARB_HLDA_TIMEOUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
module dma_priority_arbiter #(
    parameter int NUM_CH       = 4,
    parameter int CHW          = $clog2(NUM_CH),
    parameter int HLDA_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    dma_priority_arbiter_if.slave bus
);

    localparam logic [1:0]     c_ST_IDLE  = 2'd0;
    localparam logic [1:0]     c_ST_REQ   = 2'd1;
    localparam logic [1:0]     c_ST_GRANT = 2'd2;
    localparam logic [CHW-1:0] c_LAST_CH  = CHW'(NUM_CH - 1);

    logic [1:0]        state_q,    state_d;
    logic [NUM_CH-1:0] req_q,      req_d;
    logic              hrq_q,      hrq_d;
    logic              gv_q,       gv_d;
    logic [CHW-1:0]    grant_ch_q, grant_ch_d;
    logic [CHW-1:0]    prio_ptr_q, prio_ptr_d;
    logic [NUM_CH-1:0] dack_q,     dack_d;

    logic              w_any_req;
    logic [CHW-1:0]    w_base;
    logic [CHW-1:0]    w_winner;

`ifdef DMA_ARB_HLDA_TIMEOUT_EN
    localparam int              c_TO_W    = (HLDA_TIMEOUT < 256) ? 8 : 16;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(HLDA_TIMEOUT - 1);

    logic [c_TO_W-1:0] to_cnt_q, to_cnt_d;
    logic              to_err_q, to_err_d;
`else
    logic              w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (HLDA_TIMEOUT != 0);
`endif

    // Circular search starting at base; first requesting channel wins.
    function automatic logic [CHW-1:0] f_pick(
        input logic [NUM_CH-1:0] req,
        input logic [CHW-1:0]    base
    );
        logic [CHW-1:0] win;
        logic           found;
        int             idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(base) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!found && req[idx[CHW-1:0]]) begin
                found = 1'b1;
                win   = idx[CHW-1:0];
            end
        end
        return win;
    endfunction

    always_comb begin
        req_d     = ((bus.dreq ^ {NUM_CH{bus.dreq_active_low}}) | bus.sw_req) & ~bus.mask;
        w_any_req = |req_q;
        w_base    = bus.rotating_en ? prio_ptr_q : '0;
        w_winner  = f_pick(req_q, w_base);
    end

    always_comb begin
        state_d    = state_q;
        hrq_d      = hrq_q;
        gv_d       = gv_q;
        grant_ch_d = grant_ch_q;
        prio_ptr_d = prio_ptr_q;
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
        to_cnt_d   = '0;
        to_err_d   = to_err_q;
`endif

        case (state_q)
            c_ST_IDLE: begin
                if (w_any_req) begin
                    state_d = c_ST_REQ;
                    hrq_d   = 1'b1;
                end
            end

            c_ST_REQ: begin
                if (!w_any_req) begin
                    state_d = c_ST_IDLE;
                    hrq_d   = 1'b0;
                end else if (bus.hlda) begin
                    state_d    = c_ST_GRANT;
                    gv_d       = 1'b1;
                    grant_ch_d = w_winner;
                end
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
                else if (to_cnt_q == c_TO_LAST) begin
                    state_d  = c_ST_IDLE;
                    hrq_d    = 1'b0;
                    to_err_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + c_TO_W'(1);
                end
`endif
            end

            c_ST_GRANT: begin
                // Completion takes precedence over a simultaneous HLDA drop.
                if (bus.xfer_done) begin
                    state_d = c_ST_IDLE;
                    hrq_d   = 1'b0;
                    gv_d    = 1'b0;
                    if (bus.rotating_en) begin
                        prio_ptr_d = (grant_ch_q == c_LAST_CH) ? '0 : grant_ch_q + CHW'(1);
                    end
                end else if (!bus.hlda) begin
                    state_d = c_ST_IDLE;
                    hrq_d   = 1'b0;
                    gv_d    = 1'b0;
                end
            end

            default: begin
                state_d = c_ST_IDLE;
                hrq_d   = 1'b0;
                gv_d    = 1'b0;
            end
        endcase

        if (!bus.rotating_en) begin
            prio_ptr_d = '0;
        end

        // Polarity is re-applied every cycle so a command change lands on all bits at once.
        dack_d = {NUM_CH{~bus.dack_active_high}};
        if (gv_d) begin
            dack_d[grant_ch_d] = bus.dack_active_high;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= c_ST_IDLE;
            req_q      <= '0;
            hrq_q      <= 1'b0;
            gv_q       <= 1'b0;
            grant_ch_q <= '0;
            prio_ptr_q <= '0;
            dack_q     <= {NUM_CH{~bus.dack_active_high}};
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
            to_cnt_q   <= '0;
            to_err_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            hrq_q      <= hrq_d;
            gv_q       <= gv_d;
            grant_ch_q <= grant_ch_d;
            prio_ptr_q <= prio_ptr_d;
            dack_q     <= dack_d;
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            to_err_q   <= to_err_d;
`endif
        end
    end

    assign bus.hrq         = hrq_q;
    assign bus.dack        = dack_q;
    assign bus.grant_valid = gv_q;
    assign bus.grant_ch    = grant_ch_q;
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
    assign bus.timeout_err = to_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire
